// File: rtl/fifo_rd_chk.sv
// Drains a FIFO in bursts once it fills and checks that the read data forms an incrementing sequence that wraps at MAX_VAL.
// Read data is sampled RD_LAT cycles after each strobe; mismatches are counted and resynchronise the expected value.
module fifo_rd_chk #(
  parameter int DATA_W  = 8,
  parameter int MAX_VAL = 254,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              full,
  input  logic              almost_empty,
  input  logic              empty,
  input  logic              rd_rst_busy,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt,
  output logic              err,
  output logic              burst_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [DATA_W-1:0] MAX_V  = DATA_W'(MAX_VAL);
  localparam logic [1:0]        LAT_M1 = 2'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic                full_meta_q, full_meta_d;
  logic                full_d1_q, full_d1_d;
  logic [1:0]          drain_q, drain_d;
  logic                burst_done_q, burst_done_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_q, err_d;
  logic                word_vld;

  // Expected values never exceed MAX_VAL, so out-of-range words always mismatch.
  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] w);
    return (w >= MAX_V) ? '0 : w + DATA_W'(1);
  endfunction

  assign fifo_rd_en = rd_en_q & ~empty & ~rd_rst_busy;
  assign word_vld   = vld_q[RD_LAT-1];

  always_comb begin
    full_meta_d = full;
    full_d1_d   = full_meta_q;
  end

  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    drain_d      = drain_q;
    burst_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        drain_d = '0;
        if (full_d1_q && !rd_rst_busy) begin
          state_d = READ;
          rd_en_d = 1'b1;
        end
      end
      READ: begin
        drain_d = '0;
        if (rd_rst_busy)       state_d = IDLE;
        else if (almost_empty) state_d = DRAIN;
        else                   rd_en_d = 1'b1;
      end
      DRAIN: begin
        if (rd_rst_busy) begin
          state_d = IDLE;
        end else if (drain_q == LAT_M1) begin
          burst_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d[0] = fifo_rd_en;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_comb begin
    first_d   = first_q;
    exp_d     = exp_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = err_q;
    if (word_vld) begin
      first_d  = 1'b0;
      exp_d    = nxt(fifo_rd_data);
      rd_cnt_d = rd_cnt_q + 16'd1;
      if (!first_q && fifo_rd_data != exp_q) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      full_meta_q  <= 1'b0;
      full_d1_q    <= 1'b0;
      drain_q      <= '0;
      burst_done_q <= 1'b0;
      vld_q        <= '0;
      first_q      <= 1'b1;
      exp_q        <= '0;
      rd_cnt_q     <= '0;
      err_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      full_meta_q  <= full_meta_d;
      full_d1_q    <= full_d1_d;
      drain_q      <= drain_d;
      burst_done_q <= burst_done_d;
      vld_q        <= vld_d;
      first_q      <= first_d;
      exp_q        <= exp_d;
      rd_cnt_q     <= rd_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_q        <= err_d;
    end
  end

  assign rd_cnt     = rd_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err        = err_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_rd_chk.sv
// Bench for fifo_rd_chk: a model FIFO feeds directed word sequences; a monitor pops the
// hand-computed {rd_cnt, err_cnt, err} expectation each time the checker counts a word.
module tb_fifo_rd_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        full = 1'b0;
  logic        rd_rst_busy = 1'b0;
  logic        empty_force = 1'b0;
  logic        almost_empty, empty;
  logic [7:0]  fifo_rd_data = 8'd0;
  logic        fifo_rd_en, err, burst_done;
  logic [15:0] rd_cnt, err_cnt;

  logic [7:0]  src [0:255];
  int          wr_idx = 0;
  int          rd_idx = 0;

  int          checks = 0;
  int          errors = 0;
  int          bd_cnt = 0;
  logic        bd_prev = 1'b0;
  logic [15:0] prev_rc = 16'd0;

  typedef struct packed {
    logic [15:0] rc;
    logic [15:0] ec;
    logic        e;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  assign empty        = (wr_idx == rd_idx) || empty_force;
  assign almost_empty = (wr_idx - rd_idx) <= 1;

  fifo_rd_chk #(.DATA_W(8), .MAX_VAL(254), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .full         (full),
    .almost_empty (almost_empty),
    .empty        (empty),
    .rd_rst_busy  (rd_rst_busy),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .rd_cnt       (rd_cnt),
    .err_cnt      (err_cnt),
    .err          (err),
    .burst_done   (burst_done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Model FIFO with one cycle of read latency.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      chk("rd_en_while_empty", {31'd0, empty}, 32'd0);
      fifo_rd_data <= src[rd_idx[7:0]];
      rd_idx       <= rd_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rc = 16'd0;
      bd_prev = 1'b0;
    end else begin
      if (burst_done) begin
        bd_cnt++;
        chk("burst_done_width", {31'd0, bd_prev}, 32'd0);
      end
      bd_prev = burst_done;
      if (rd_cnt != prev_rc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: rd_cnt %0d with no expected entry", rd_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_rd_cnt", {16'd0, rd_cnt}, {16'd0, mon_e.rc});
          chk("sb_err_cnt", {16'd0, err_cnt}, {16'd0, mon_e.ec});
          chk("sb_err", {31'd0, err}, {31'd0, mon_e.e});
        end
        prev_rc = rd_cnt;
      end
    end
  end

  task automatic push_src(input logic [7:0] w);
    src[wr_idx[7:0]] = w;
    wr_idx++;
  endtask

  task automatic push_exp(input int rc, input int ec, input logic e);
    exp_t x;
    x.rc = 16'(rc);
    x.ec = 16'(ec);
    x.e  = e;
    exp_q.push_back(x);
  endtask

  task automatic load_word(input logic [7:0] w, input int rc, input int ec, input logic e);
    push_src(w);
    push_exp(rc, ec, e);
  endtask

  // Raises full at a falling edge and returns once the first strobe is visible.
  task automatic start_burst(input string nm);
    int lat;
    lat = 0;
    full = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!fifo_rd_en && lat < 20);
    chk(nm, 32'(lat), 32'd3);
    full = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int rc_target, input int bd_target);
    int n;
    n = 0;
    while ((rd_cnt != 16'(rc_target) || wr_idx != rd_idx) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_in_time"}, 32'(n < 300), 32'd1);
    repeat (4) @(negedge clk);
    chk({nm, "_rd_cnt"}, {16'd0, rd_cnt}, 32'(rc_target));
    chk({nm, "_burst_done"}, 32'(bd_cnt), 32'(bd_target));
    chk({nm, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b_w [7];
    logic [7:0] c_w [4];
    b_w = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd0, 8'd1};
    c_w = '{8'd5, 8'd6, 8'd9, 8'd10};

    repeat (3) @(negedge clk);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full burst of 0..15.
    for (int i = 0; i < 16; i++) load_word(8'(i), i + 1, 0, 1'b0);
    start_burst("a_latency");
    wait_done("a", 16, 1);
    chk("a_words_read", 32'(rd_idx), 32'd16);
    chk("a_err", {31'd0, err}, 32'd0);

    // Wrap through MAX_VAL.
    do_reset();
    for (int i = 0; i < 7; i++) load_word(b_w[i], i + 1, 0, 1'b0);
    start_burst("b_latency");
    wait_done("b", 7, 2);
    chk("b_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Single gap, then resync.
    do_reset();
    load_word(c_w[0], 1, 0, 1'b0);
    load_word(c_w[1], 2, 0, 1'b0);
    load_word(c_w[2], 3, 1, 1'b1);
    load_word(c_w[3], 4, 1, 1'b1);
    start_burst("c_latency");
    wait_done("c", 4, 3);
    chk("c_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("c_err", {31'd0, err}, 32'd1);

    // Read-side reset mid-burst; state and counters carry over from the previous burst.
    for (int i = 0; i < 8; i++) load_word(8'(11 + i), 5 + i, 1, 1'b1);
    start_burst("d_latency");
    repeat (2) @(negedge clk);
    chk("d_en_before_busy", {31'd0, fifo_rd_en}, 32'd1);
    rd_rst_busy = 1'b1;
    #1;
    chk("d_en_drop", {31'd0, fifo_rd_en}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("d_en_busy", {31'd0, fifo_rd_en}, 32'd0);
    end
    rd_rst_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("d_en_idle", {31'd0, fifo_rd_en}, 32'd0);
    end
    chk("d_rd_cnt_mid", {16'd0, rd_cnt}, 32'd6);
    chk("d_no_burst_done", 32'(bd_cnt), 32'd3);
    chk("d_words_left", 32'(wr_idx - rd_idx), 32'd6);
    start_burst("d2_latency");
    wait_done("d", 12, 4);

    // Empty held while the strobe register is set.
    for (int i = 0; i < 8; i++) load_word(8'(19 + i), 13 + i, 1, 1'b1);
    start_burst("e_latency");
    empty_force = 1'b1;
    #1;
    chk("e_en_empty", {31'd0, fifo_rd_en}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("e_en_held", {31'd0, fifo_rd_en}, 32'd0);
      chk("e_rd_cnt_held", {16'd0, rd_cnt}, 32'd12);
    end
    empty_force = 1'b0;
    wait_done("e", 20, 5);

    // Core reset in READ.
    for (int i = 0; i < 8; i++) push_src(8'(27 + i));
    start_burst("f_latency");
    rst_n = 1'b0;
    #1;
    chk("f_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("f_rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    chk("f_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("f_rst_err", {31'd0, err}, 32'd0);
    chk("f_rst_burst_done", {31'd0, burst_done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_exp(i + 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("f_no_read", {31'd0, fifo_rd_en}, 32'd0);
    end
    chk("f_words_left", 32'(wr_idx - rd_idx), 32'd8);
    start_burst("f2_latency");
    wait_done("f", 8, 6);
    chk("f_err", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
